// File: rtl/io_arb_pkg.sv
// Shared types and default sizing for the two-port IO bus arbiter.
// Used by io_arb_pick and io_bus_arbiter.
package io_arb_pkg;

  localparam int N_PORTS      = 2;
  localparam int ADDR_W_DEF   = 12;
  localparam int DATA_W_DEF   = 32;
  localparam int MAX_ADDR_DEF = 'hFFC;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } arb_state_t;

endpackage : io_arb_pkg

// File: rtl/io_arb_pick.sv
// Grant selection for the IO bus arbiter: one-hot grant from two requests.
// IO_ARB_RR_EN selects round-robin; otherwise port 0 has fixed priority.
module io_arb_pick
  import io_arb_pkg::*;
(
  input  logic [N_PORTS-1:0] req,
  input  logic               last_owner,
  output logic [N_PORTS-1:0] grant
);

`ifdef IO_ARB_RR_EN
  // On a tie the port that did not win last time takes the bus.
  assign grant[0] = req[0] & (~req[1] | last_owner);
  assign grant[1] = req[1] & (~req[0] | ~last_owner);
`else
  logic unused_last_owner;
  assign unused_last_owner = last_owner;

  assign grant[0] = req[0];
  assign grant[1] = req[1] & ~req[0];
`endif

endmodule : io_arb_pick

// File: rtl/io_bus_arbiter.sv
// Two-port arbiter and access sequencer for the 4 KB IO space (IDLE/ACCESS/DONE).
// Define IO_ARB_RR_EN for round-robin arbitration; default is port 0 fixed priority.
module io_bus_arbiter
  import io_arb_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter int                DATA_W   = DATA_W_DEF,
  parameter logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'(MAX_ADDR_DEF)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              wr0,
  input  logic              wr1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              done0,
  output logic              done1,
  output logic              err,
  output logic [DATA_W-1:0] rdata,
  output logic              io_cs,
  output logic              io_rd,
  output logic              io_wr,
  output logic [ADDR_W-1:0] io_addr,
  output logic [DATA_W-1:0] io_wdata,
  input  logic [DATA_W-1:0] io_rdata
);

  arb_state_t         state_q, state_d;
  logic [N_PORTS-1:0] req_vec;
  logic [N_PORTS-1:0] grant;
  logic               last_owner;
  logic               start;

  logic               sel_port;
  logic               sel_wr;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_wdata;
  logic               sel_bad;

  logic               owner_q;
  logic               wr_q;
  logic               err_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [DATA_W-1:0]  rdata_q;
  logic               in_access;
  logic               in_done;

  assign req_vec = {req1, req0};

  io_arb_pick u_pick (
    .req        (req_vec),
    .last_owner (last_owner),
    .grant      (grant)
  );

  assign start     = (state_q == ST_IDLE) && (|grant);
  assign sel_port  = grant[1];
  assign sel_wr    = sel_port ? wr1    : wr0;
  assign sel_addr  = sel_port ? addr1  : addr0;
  assign sel_wdata = sel_port ? wdata1 : wdata0;
  assign sel_bad   = sel_addr > MAX_ADDR;

`ifdef IO_ARB_RR_EN
  logic last_q;

  // Reset value 1 makes port 0 the winner of the first tie.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)   last_q <= 1'b1;
    else if (start) last_q <= sel_port;
  end

  assign last_owner = last_q;
`else
  assign last_owner = 1'b1;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (|grant) state_d = sel_bad ? ST_DONE : ST_ACCESS;
      ST_ACCESS: state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // NOTE: the request latches and rdata are reset as well, because rdata must
  // read 0 during reset and the latched values feed the bus outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      owner_q <= 1'b0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (start) begin
      owner_q <= sel_port;
      wr_q    <= sel_wr;
      err_q   <= sel_bad;
      addr_q  <= sel_addr;
      wdata_q <= sel_wdata;
    end
  end

  // Read data is captured on the edge that ends ACCESS and held afterwards.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                                 rdata_q <= '0;
    else if ((state_q == ST_ACCESS) && !wr_q)     rdata_q <= io_rdata;
  end

  // Bus strobes decode straight from the state register, so an async reset
  // during ACCESS drops io_wr before the commit edge.
  assign in_access = (state_q == ST_ACCESS);
  assign in_done   = (state_q == ST_DONE);

  assign io_cs    = in_access;
  assign io_rd    = in_access & ~wr_q;
  assign io_wr    = in_access &  wr_q;
  assign io_addr  = in_access ? addr_q  : '0;
  assign io_wdata = in_access ? wdata_q : '0;

  assign done0 = in_done & ~owner_q;
  assign done1 = in_done &  owner_q;
  assign err   = in_done &  err_q;
  assign rdata = rdata_q;

endmodule : io_bus_arbiter
